// File: rtl/kp_pkg.sv
// ============================================================================
// Module  : kp_pkg
// Brief   : Shared types and constants for the keypoint collector.
// Revision: 1.0
// ============================================================================
`default_nettype none

package kp_pkg;

    localparam int KP_X_W = 10;
    localparam int ORI_W  = 12;

    // null_rec tags the terminator record of a frame with no keypoints
    typedef struct packed {
        logic [KP_X_W-1:0] x;
        logic [KP_X_W-1:0] y;
        logic [7:0]        score;
        logic [ORI_W-1:0]  cos;
        logic [ORI_W-1:0]  sin;
        logic              last;
        logic              null_rec;
    } kp_t;

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_COLLECT = 1'b1
    } state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/kp_collector_if.sv
// ============================================================================
// Module  : kp_collector_if
// Brief   : Valid/ready keypoint record bus from collector to consumer.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface kp_collector_if;
    import kp_pkg::*;

    logic              o_kp_valid;
    logic              i_kp_ready;
    logic [KP_X_W-1:0] o_kp_x;
    logic [KP_X_W-1:0] o_kp_y;
    logic [7:0]        o_kp_score;
    logic [ORI_W-1:0]  o_kp_cos;
    logic [ORI_W-1:0]  o_kp_sin;
    logic              o_kp_last;
    logic              o_kp_null;

    modport master (
        output o_kp_valid, o_kp_x, o_kp_y, o_kp_score, o_kp_cos, o_kp_sin,
               o_kp_last, o_kp_null,
        input  i_kp_ready
    );

    modport slave (
        input  o_kp_valid, o_kp_x, o_kp_y, o_kp_score, o_kp_cos, o_kp_sin,
               o_kp_last, o_kp_null,
        output i_kp_ready
    );

endinterface

`default_nettype wire

// File: rtl/kp_fifo.sv
// ============================================================================
// Module  : kp_fifo
// Brief   : Show-ahead FIFO of kp_t records with occupancy and full flags.
// Revision: 1.0
// ============================================================================
`default_nettype none

module kp_fifo
    import kp_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  wire logic                     i_clk,
    input  wire logic                     i_rst_n,
    input  wire logic                     i_push,
    input  wire kp_t                      i_data,
    input  wire logic                     i_pop,
    output kp_t                           o_data,
    output logic [$clog2(DEPTH):0]        o_count,
    output logic                          o_full,
    output logic                          o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    kp_t           mem_q [DEPTH];
    logic          w_push;
    logic          w_pop;

    assign o_full  = (count_q == (AW+1)'(DEPTH));
    assign o_empty = (count_q == '0);
    assign o_count = count_q;
    assign o_data  = mem_q[rd_ptr_q];

    assign w_pop  = i_pop & ~o_empty;
    assign w_push = i_push & (~o_full | w_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (w_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; the pointers define which entries are live
    always_ff @(posedge i_clk) begin
        if (w_push) mem_q[wr_ptr_q] <= i_data;
    end

endmodule

`default_nettype wire

// File: rtl/kp_collector.sv
// ============================================================================
// Module  : kp_collector
// Brief   : Keeps flagged FAST keypoints, buffers them and tags frame ends.
//           Optional KPC_SCORE_FILTER_EN adds a score threshold input.
// Revision: 1.0
// ============================================================================
`default_nettype none

module kp_collector
    import kp_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int MAX_KP = 500
) (
    input  wire logic              i_clk,
    input  wire logic              i_rst_n,
    input  wire logic              i_start,
    input  wire logic              i_end,
    input  wire logic              i_point_valid,
    input  wire logic              i_flag,
    input  wire logic [KP_X_W-1:0] i_x,
    input  wire logic [KP_X_W-1:0] i_y,
    input  wire logic [7:0]        i_score,
    input  wire logic [ORI_W-1:0]  i_cos,
    input  wire logic [ORI_W-1:0]  i_sin,
`ifdef KPC_SCORE_FILTER_EN
    input  wire logic [7:0]        i_score_thresh,
`endif
    kp_collector_if.master         kp_if,
    output logic [9:0]             o_kp_count,
    output logic [15:0]            o_drop_count,
    output logic                   o_overflow,
    output logic                   o_frame_done,
    output logic                   o_busy
);

    localparam int          AW           = $clog2(DEPTH);
    localparam logic [AW:0] C_PUSH_LIMIT = (AW+1)'(DEPTH - 1);
    localparam logic [9:0]  C_MAX_KP     = 10'(MAX_KP);

    state_t      state_q, state_d;
    kp_t         stg_q, stg_d;
    logic        stg_occ_q, stg_occ_d;
    logic [9:0]  kp_count_q, kp_count_d;
    logic [15:0] drop_q, drop_d;
    logic        ovf_q, ovf_d;
    logic        done_q, done_d;

    logic        w_cand;
    logic        w_push;
    kp_t         w_push_data;
    kp_t         w_incoming;
    kp_t         w_head;
    kp_t         w_head_vis;
    logic [AW:0] w_fifo_count;
    logic        w_fifo_full;
    logic        w_fifo_empty;
    logic        w_fifo_tight;
    logic        w_pop;

`ifdef KPC_SCORE_FILTER_EN
    assign w_cand = i_point_valid & i_flag & (i_score >= i_score_thresh);
`else
    assign w_cand = i_point_valid & i_flag;
`endif

    always_comb begin
        w_incoming          = '0;
        w_incoming.x        = i_x;
        w_incoming.y        = i_y;
        w_incoming.score    = i_score;
        w_incoming.cos      = i_cos;
        w_incoming.sin      = i_sin;
    end

    // Last slot is held back so a frame terminator can always be pushed
    assign w_fifo_tight = w_fifo_full | (w_fifo_count == C_PUSH_LIMIT);

    always_comb begin
        state_d     = state_q;
        stg_d       = stg_q;
        stg_occ_d   = stg_occ_q;
        kp_count_d  = kp_count_q;
        drop_d      = drop_q;
        ovf_d       = ovf_q;
        done_d      = 1'b0;
        w_push      = 1'b0;
        w_push_data = stg_q;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d    = S_COLLECT;
                    kp_count_d = '0;
                    drop_d     = {15'd0, w_cand};
                    ovf_d      = w_cand;
                end
            end
            S_COLLECT: begin
                if (i_start || i_end) begin
                    w_push    = 1'b1;
                    done_d    = 1'b1;
                    stg_occ_d = 1'b0;
                    if (!stg_occ_q) begin
                        w_push_data          = '0;
                        w_push_data.null_rec = 1'b1;
                    end
                    w_push_data.last = 1'b1;
                    if (i_start) begin
                        kp_count_d = '0;
                        drop_d     = {15'd0, w_cand};
                        ovf_d      = w_cand;
                    end else begin
                        state_d = S_IDLE;
                        if (w_cand) begin
                            drop_d = sat_inc16(drop_q);
                            ovf_d  = 1'b1;
                        end
                    end
                end else if (w_cand) begin
                    if ((stg_occ_q && w_fifo_tight) || (kp_count_q == C_MAX_KP)) begin
                        drop_d = sat_inc16(drop_q);
                        ovf_d  = 1'b1;
                    end else begin
                        w_push     = stg_occ_q;
                        stg_d      = w_incoming;
                        stg_occ_d  = 1'b1;
                        kp_count_d = kp_count_q + 10'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            stg_q      <= '0;
            stg_occ_q  <= 1'b0;
            kp_count_q <= '0;
            drop_q     <= '0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            stg_q      <= stg_d;
            stg_occ_q  <= stg_occ_d;
            kp_count_q <= kp_count_d;
            drop_q     <= drop_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
        end
    end

    kp_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_count (w_fifo_count),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign w_pop      = ~w_fifo_empty & kp_if.i_kp_ready;
    assign w_head_vis = w_fifo_empty ? '0 : w_head;

    assign kp_if.o_kp_valid = ~w_fifo_empty;
    assign kp_if.o_kp_x     = w_head_vis.x;
    assign kp_if.o_kp_y     = w_head_vis.y;
    assign kp_if.o_kp_score = w_head_vis.score;
    assign kp_if.o_kp_cos   = w_head_vis.cos;
    assign kp_if.o_kp_sin   = w_head_vis.sin;
    assign kp_if.o_kp_last  = w_head_vis.last;
    assign kp_if.o_kp_null  = w_head_vis.null_rec;

    assign o_kp_count   = kp_count_q;
    assign o_drop_count = drop_q;
    assign o_overflow   = ovf_q;
    assign o_frame_done = done_q;
    assign o_busy       = (state_q == S_COLLECT);

endmodule

`default_nettype wire

// File: tb/tb_kp_collector.sv
// ============================================================================
// Module  : tb_kp_collector
// Brief   : Self-checking bench for kp_collector (DEPTH=8, MAX_KP=10).
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_kp_collector;
    import kp_pkg::*;

    localparam int DEPTH  = 8;
    localparam int MAX_KP = 10;

    localparam logic [1:0] OP_IDLE  = 2'd0;
    localparam logic [1:0] OP_START = 2'd1;
    localparam logic [1:0] OP_END   = 2'd2;
    localparam logic [1:0] OP_KP    = 2'd3;

    typedef struct {
        logic [1:0] op;
        logic       pv;
        logic       flag;
        logic [9:0] x;
        logic [9:0] y;
        logic [7:0] sc;
        logic       admit;
        int         exp_count;
        int         exp_drop;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        st = 1'b0, en = 1'b0, pv = 1'b0, flag = 1'b0;
    logic [9:0]  x = '0, y = '0;
    logic [7:0]  sc = '0;
    logic [11:0] co = '0, si = '0;
    logic [9:0]  kp_count;
    logic [15:0] drop_count;
    logic        overflow, frame_done, busy;

    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;
    int   admits = 0;
    bit   in_frame = 1'b0;
    kp_t  exp_q[$];
    kp_t  mon_got, mon_exp;
    vec_t tbl[19];

    kp_collector_if kp_if();

    kp_collector #(.DEPTH(DEPTH), .MAX_KP(MAX_KP)) u_dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_start       (st),
        .i_end         (en),
        .i_point_valid (pv),
        .i_flag        (flag),
        .i_x           (x),
        .i_y           (y),
        .i_score       (sc),
        .i_cos         (co),
        .i_sin         (si),
        .kp_if         (kp_if),
        .o_kp_count    (kp_count),
        .o_drop_count  (drop_count),
        .o_overflow    (overflow),
        .o_frame_done  (frame_done),
        .o_busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    function automatic kp_t mk(input logic [9:0] px, input logic [9:0] py, input logic [7:0] ps);
        kp_t r;
        r       = '0;
        r.x     = px;
        r.y     = py;
        r.score = ps;
        r.cos   = {2'b01, px};
        r.sin   = {2'b10, py};
        return r;
    endfunction

    function automatic vec_t row(input logic [1:0] op, input logic p, input logic f,
                                 input int px, input int py, input int ps,
                                 input logic a, input int c, input int d);
        vec_t v;
        v.op = op; v.pv = p; v.flag = f;
        v.x = 10'(px); v.y = 10'(py); v.sc = 8'(ps);
        v.admit = a; v.exp_count = c; v.exp_drop = d;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic terminate();
        kp_t n;
        if (admits > 0) begin
            exp_q[exp_q.size()-1].last = 1'b1;
        end else begin
            n = '0;
            n.last = 1'b1;
            n.null_rec = 1'b1;
            exp_q.push_back(n);
        end
        admits = 0;
    endtask

    // Record expectations before the stimulus is driven
    task automatic apply(input logic [1:0] op, input logic p, input logic f,
                         input logic [9:0] px, input logic [9:0] py, input logic [7:0] ps,
                         input logic admit);
        case (op)
            OP_START: begin if (in_frame) terminate(); in_frame = 1'b1; end
            OP_END:   begin if (in_frame) terminate(); in_frame = 1'b0; end
            OP_KP:    if (admit) begin exp_q.push_back(mk(px, py, ps)); admits++; end
            default:  ;
        endcase
        st = (op == OP_START); en = (op == OP_END);
        pv = p; flag = f; x = px; y = py; sc = ps;
        co = {2'b01, px}; si = {2'b10, py};
        @(posedge clk); #1;
        st = 1'b0; en = 1'b0; pv = 1'b0; flag = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply(OP_IDLE, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    endtask

    task automatic drain();
        for (int c = 0; c < 200 && exp_q.size() != 0; c++) begin
            @(posedge clk); #1;
        end
        chk("drain_left", exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_done) done_cnt++;
            if (kp_if.o_kp_valid && kp_if.i_kp_ready) begin
                mon_got = {kp_if.o_kp_x, kp_if.o_kp_y, kp_if.o_kp_score, kp_if.o_kp_cos,
                           kp_if.o_kp_sin, kp_if.o_kp_last, kp_if.o_kp_null};
                chk("sb_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    mon_exp = exp_q.pop_front();
                    chk("record", mon_got, mon_exp);
                end
            end
        end
    end

    initial begin
        kp_if.i_kp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", kp_if.o_kp_valid, 0);
        chk("rst_count", kp_count, 0);
        chk("rst_drop", drop_count, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // op, pv, flag, x, y, score, admit, count, drop
        tbl[0]  = row(OP_START, 0, 0,   0,  0,  0, 0, 0, 0);
        tbl[1]  = row(OP_KP,    1, 1,  40, 50, 30, 1, 1, 0);
        tbl[2]  = row(OP_KP,    1, 0,   7,  8,  9, 0, 1, 0);
        tbl[3]  = row(OP_KP,    0, 1,   9,  9,  9, 0, 1, 0);
        tbl[4]  = row(OP_KP,    1, 1, 100, 60, 25, 1, 2, 0);
        tbl[5]  = row(OP_END,   0, 0,   0,  0,  0, 0, 2, 0);
        tbl[6]  = row(OP_IDLE,  0, 0,   0,  0,  0, 0, 2, 0);
        tbl[7]  = row(OP_KP,    1, 1,   3,  3,  3, 0, 2, 0);
        tbl[8]  = row(OP_END,   0, 0,   0,  0,  0, 0, 2, 0);
        tbl[9]  = row(OP_START, 0, 0,   0,  0,  0, 0, 0, 0);
        tbl[10] = row(OP_KP,    1, 0,   1,  2,  3, 0, 0, 0);
        tbl[11] = row(OP_END,   0, 0,   0,  0,  0, 0, 0, 0);
        tbl[12] = row(OP_START, 0, 0,   0,  0,  0, 0, 0, 0);
        tbl[13] = row(OP_KP,    1, 1,   5,  6,  7, 1, 1, 0);
        tbl[14] = row(OP_END,   1, 1,  11, 12, 13, 0, 1, 1);
        tbl[15] = row(OP_START, 1, 1,  14, 15, 16, 0, 0, 1);
        tbl[16] = row(OP_END,   0, 0,   0,  0,  0, 0, 0, 1);
        tbl[17] = row(OP_IDLE,  0, 0,   0,  0,  0, 0, 0, 1);
        tbl[18] = row(OP_IDLE,  0, 0,   0,  0,  0, 0, 0, 1);

        done_cnt = 0;
        for (int i = 0; i < 19; i++) begin
            apply(tbl[i].op, tbl[i].pv, tbl[i].flag, tbl[i].x, tbl[i].y, tbl[i].sc, tbl[i].admit);
            chk("tbl_count", kp_count, tbl[i].exp_count);
            chk("tbl_drop", drop_count, tbl[i].exp_drop);
            chk("tbl_ovf", overflow, tbl[i].exp_drop != 0);
        end
        drain();
        chk("tbl_frame_done", done_cnt, 4);

        // FIFO fills with consumer stalled: 7 pushes + staged record admitted
        kp_if.i_kp_ready = 1'b0;
        done_cnt = 0;
        apply(OP_START, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        for (int i = 0; i < 21; i++)
            apply(OP_KP, 1'b1, 1'b1, 10'(i), 10'(i + 1), 8'(i), i < 8);
        apply(OP_END, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        idle(2);
        chk("full_count", kp_count, 8);
        chk("full_drop", drop_count, 13);
        chk("full_ovf", overflow, 1);
        chk("full_valid", kp_if.o_kp_valid, 1);
        chk("full_hold_x", kp_if.o_kp_x, 0);
        chk("full_done", done_cnt, 1);
        kp_if.i_kp_ready = 1'b1;
        drain();

        // Per-frame keypoint cap
        apply(OP_START, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        for (int i = 0; i < 12; i++)
            apply(OP_KP, 1'b1, 1'b1, 10'(200 + i), 10'(i), 8'(50 + i), i < MAX_KP);
        apply(OP_END, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        idle(1);
        chk("max_count", kp_count, MAX_KP);
        chk("max_drop", drop_count, 2);
        chk("max_busy", busy, 0);
        drain();

        // Abort by a second i_start
        done_cnt = 0;
        apply(OP_START, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        apply(OP_KP, 1'b1, 1'b1, 10'd300, 10'd1, 8'd1, 1'b1);
        apply(OP_KP, 1'b1, 1'b1, 10'd301, 10'd2, 8'd2, 1'b1);
        chk("abort_pre_count", kp_count, 2);
        apply(OP_START, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        chk("abort_count", kp_count, 0);
        chk("abort_busy", busy, 1);
        apply(OP_KP, 1'b1, 1'b1, 10'd302, 10'd3, 8'd3, 1'b1);
        apply(OP_END, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        idle(1);
        chk("abort_b_count", kp_count, 1);
        drain();
        chk("abort_done", done_cnt, 2);

        // Reset mid-frame with entries in the FIFO
        kp_if.i_kp_ready = 1'b0;
        apply(OP_START, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        for (int i = 0; i < 6; i++)
            apply(OP_KP, 1'b1, 1'b1, 10'(400 + i), 10'(i), 8'(i), 1'b1);
        idle(1);
        chk("pre_rst_valid", kp_if.o_kp_valid, 1);
        chk("pre_rst_count", kp_count, 6);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", kp_if.o_kp_valid, 0);
        chk("arst_count", kp_count, 0);
        chk("arst_busy", busy, 0);
        exp_q.delete();
        in_frame = 1'b0;
        admits = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        apply(OP_KP, 1'b1, 1'b1, 10'd9, 10'd9, 8'd9, 1'b0);
        idle(2);
        chk("post_rst_count", kp_count, 0);
        chk("post_rst_valid", kp_if.o_kp_valid, 0);
        chk("post_rst_busy", busy, 0);
        kp_if.i_kp_ready = 1'b1;
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
